// File: rtl/add_sequencer.sv
// Byte-serial adder: one 8-bit carry-select slice is reused across all operand
// bytes, LSB first, producing a registered sum, carry out and signed overflow.

module carry_select_slice8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  // Upper nibble is precomputed for both possible carries, then selected.
  assign lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
  assign hi0  = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign hi1  = hi0 + 5'd1;
  assign s    = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
  assign cout = lo[4] ? hi1[4] : hi0[4];
endmodule

module add_sequencer #(
  parameter int N_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*N_BYTES-1:0] A,
  input  logic [8*N_BYTES-1:0] B,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [8*N_BYTES-1:0] S,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W     = 8 * N_BYTES;
  localparam int IDX_W = $clog2(N_BYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             c;
  logic [7:0]       a_byte [N_BYTES];
  logic [7:0]       b_byte [N_BYTES];
  logic [7:0]       acc    [N_BYTES];

  logic [7:0]       cur_a;
  logic [7:0]       cur_b;
  logic [7:0]       slice_s;
  logic             slice_c;
  logic [W-1:0]     final_sum;

  assign cur_a = a_byte[idx];
  assign cur_b = b_byte[idx];

  carry_select_slice8 u_slice (
    .a    (cur_a),
    .b    (cur_b),
    .cin  (c),
    .s    (slice_s),
    .cout (slice_c)
  );

  // Completed sum: the byte being added this cycle bypasses the accumulator.
  for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_final
    assign final_sum[gi*8 +: 8] = (idx == IDX_W'(gi)) ? slice_s : acc[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      c     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      for (int i = 0; i < N_BYTES; i++) begin
        a_byte[i] <= '0;
        b_byte[i] <= '0;
        acc[i]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N_BYTES; i++) begin
              a_byte[i] <= A[i*8 +: 8];
              b_byte[i] <= B[i*8 +: 8];
            end
            c     <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc[idx] <= slice_s;
          c        <= slice_c;
          if (idx == LAST) begin
            S     <= final_sum;
            cout  <= slice_c;
            // Carry into the MSB is recovered from the sign-bit sum.
            ovf   <= cur_a[7] ^ cur_b[7] ^ slice_s[7] ^ slice_c;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
